// File: rtl/lcd_controller.sv
// Control-path sequencer for an HD44780-style character LCD on an 8-bit bus.
// Power-up delay, four init commands, then endless two-position refresh.
module lcd_controller #(
    parameter int POWERUP_MS  = 20,
    parameter int CMD_WAIT_MS = 2,
    parameter int REFRESH_MS  = 50
) (
    input  logic       clk_1ms,
    input  logic       reset,
    output logic       data_sel,
    output logic       DB_sel,
    output logic [1:0] init_sel,
    output logic [1:0] mux_sel,
    output logic       E_out,
    output logic       RW_out,
    output logic       RS_out
);

    localparam int MAX_MS = (POWERUP_MS > CMD_WAIT_MS) ?
                            ((POWERUP_MS > REFRESH_MS) ? POWERUP_MS : REFRESH_MS) :
                            ((CMD_WAIT_MS > REFRESH_MS) ? CMD_WAIT_MS : REFRESH_MS);
    localparam int CNT_W = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_MS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CMD_WAIT_MS - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(REFRESH_MS - 1);

    typedef enum logic [2:0] {
        S_POWERUP, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic [1:0]       ref_idx_q, ref_idx_d;
    logic             in_ref_q, in_ref_d;
    logic             data_sel_q, data_sel_d;
    logic             db_sel_q, db_sel_d;
    logic [1:0]       init_sel_q, init_sel_d;
    logic [1:0]       mux_sel_q, mux_sel_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        ref_idx_d  = ref_idx_q;
        in_ref_d   = in_ref_q;
        data_sel_d = data_sel_q;
        db_sel_d   = db_sel_q;
        init_sel_d = init_sel_q;
        mux_sel_d  = mux_sel_q;
        e_d        = 1'b0;
        rs_d       = rs_q;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                e_d     = 1'b1;
            end
            S_PULSE: state_d = S_HOLD;
            S_HOLD: begin
                state_d  = S_WAIT;
                db_sel_d = 1'b0;
                cnt_d    = '0;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d = '0;
                    if (!in_ref_q) begin
                        state_d = S_SETUP;
                        if (init_idx_q == 2'd3) begin
                            in_ref_d  = 1'b1;
                            ref_idx_d = 2'd0;
                        end else begin
                            init_idx_d = init_idx_q + 2'd1;
                        end
                    end else if (ref_idx_q == 2'd3) begin
                        state_d   = S_IDLE;
                        ref_idx_d = 2'd0;
                        rs_d      = 1'b0;
                    end else begin
                        state_d   = S_SETUP;
                        ref_idx_d = ref_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_POWERUP;
        endcase

        // Selects only move on SETUP entry, so they are settled a full cycle before E rises.
        if (state_d == S_SETUP && state_q != S_SETUP) begin
            db_sel_d   = 1'b1;
            init_sel_d = init_idx_d;
            if (in_ref_d) begin
                mux_sel_d  = ref_idx_d[0] ? 2'd2 : 2'd1;
                data_sel_d = ref_idx_d[1];
                rs_d       = ref_idx_d[0];
            end else begin
                mux_sel_d  = 2'd0;
                data_sel_d = 1'b0;
                rs_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            state_q    <= S_POWERUP;
            cnt_q      <= '0;
            init_idx_q <= 2'd0;
            ref_idx_q  <= 2'd0;
            in_ref_q   <= 1'b0;
            data_sel_q <= 1'b0;
            db_sel_q   <= 1'b0;
            init_sel_q <= 2'd0;
            mux_sel_q  <= 2'd0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            ref_idx_q  <= ref_idx_d;
            in_ref_q   <= in_ref_d;
            data_sel_q <= data_sel_d;
            db_sel_q   <= db_sel_d;
            init_sel_q <= init_sel_d;
            mux_sel_q  <= mux_sel_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
        end
    end

    assign data_sel = data_sel_q;
    assign DB_sel   = db_sel_q;
    assign init_sel = init_sel_q;
    assign mux_sel  = mux_sel_q;
    assign E_out    = e_q;
    assign RS_out   = rs_q;
    assign RW_out   = 1'b0;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller: a short-parameter instance checked against an
// expected-pulse queue, plus a default-parameter instance checked for init timing.
module tb_lcd_controller;

    localparam int P = 2;
    localparam int W = 1;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_sel, DB_sel, E_out, RW_out, RS_out;
    logic [1:0] init_sel, mux_sel;
    logic       d_data_sel, d_DB_sel, d_E_out, d_RW_out, d_RS_out;
    logic [1:0] d_init_sel, d_mux_sel;

    always #5 clk = ~clk;

    lcd_controller #(.POWERUP_MS(P), .CMD_WAIT_MS(W), .REFRESH_MS(R)) dut (
        .clk_1ms(clk), .reset(reset), .data_sel(data_sel), .DB_sel(DB_sel),
        .init_sel(init_sel), .mux_sel(mux_sel), .E_out(E_out), .RW_out(RW_out),
        .RS_out(RS_out)
    );

    lcd_controller dut_def (
        .clk_1ms(clk), .reset(reset), .data_sel(d_data_sel), .DB_sel(d_DB_sel),
        .init_sel(d_init_sel), .mux_sel(d_mux_sel), .E_out(d_E_out), .RW_out(d_RW_out),
        .RS_out(d_RS_out)
    );

    typedef struct {
        int cyc;
        int isel;
        int msel;
        int dsel;
        int rs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   def_cnt = 0;

    logic       prev_e = 1'b0;
    logic       hold_chk = 1'b0;
    logic [5:0] sel_prev = '0;
    logic [5:0] sel_pulse = '0;
    logic [5:0] sel_now;
    logic [8:0] all_outs;

    assign sel_now  = {init_sel, mux_sel, data_sel, RS_out};
    assign all_outs = {data_sel, DB_sel, init_sel, mux_sel, E_out, RW_out, RS_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_until(input int n);
        int lim = 0;
        while (cyc != n && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        if (cyc != n) chk("timeout", cyc, n);
    endtask

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_t e;
            chk("rw_zero", RW_out, 0);
            chk("mux_not3", mux_sel == 2'd3, 0);
            if (prev_e) chk("e_twice", E_out, 0);
            if (hold_chk) begin
                chk("hold_sel", sel_now, sel_pulse);
                chk("hold_db", DB_sel, 1);
            end
            hold_chk <= 1'b0;
            if (E_out) begin
                chk("setup_sel", sel_now, sel_prev);
                chk("pulse_db", DB_sel, 1);
                sel_pulse <= sel_now;
                hold_chk  <= 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_isel", init_sel, e.isel);
                    chk("pulse_msel", mux_sel, e.msel);
                    chk("pulse_dsel", data_sel, e.dsel);
                    chk("pulse_rs", RS_out, e.rs);
                end
            end
            prev_e   <= E_out;
            sel_prev <= sel_now;
        end else begin
            prev_e   <= 1'b0;
            hold_chk <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset && d_E_out && def_cnt < 4) begin
            chk("def_cyc", cyc, 21 + 5 * def_cnt);
            chk("def_isel", d_init_sel, def_cnt);
            def_cnt <= def_cnt + 1;
        end
    end

    initial begin
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", all_outs, 0);
        end

        for (int i = 0; i < 4; i++) q.push_back('{3 + 4 * i, i, 0, 0, 0});
        for (int k = 0; k < 4; k++)
            q.push_back('{19 + 4 * k, 3, (k % 2) ? 2 : 1, k / 2, k % 2});
        for (int k = 0; k < 2; k++)
            q.push_back('{38 + 4 * k, 3, (k % 2) ? 2 : 1, k / 2, k % 2});

        reset = 1'b1;
        @(negedge clk);
        chk("powerup_c1", all_outs, 0);
        @(negedge clk);
        chk("setup_db", DB_sel, 1);
        chk("setup_e", E_out, 0);
        chk("setup_mux", mux_sel, 0);
        chk("setup_isel", init_sel, 0);
        chk("setup_rs", RS_out, 0);

        wait_until(34);
        for (int i = 0; i < R; i++) begin
            chk("idle_e", E_out, 0);
            chk("idle_db", DB_sel, 0);
            @(negedge clk);
        end

        wait_until(42);
        chk("pre_rst_e", E_out, 1);
        #1 reset = 1'b0;
        #1 chk("async_clr", all_outs, 0);
        chk("q_drained", q.size(), 0);
        repeat (2) @(negedge clk);
        chk("rst_mid_hold", all_outs, 0);

        q.push_back('{3, 0, 0, 0, 0});
        reset = 1'b1;
        wait_until(5);
        chk("restart_seen", q.size(), 0);
        chk("def_pulses", def_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
- Control-path FSM for an HD44780-compatible character LCD on an 8-bit bus, with the write strobe timed directly off a 1 ms clock.
- Drives the LCD strobes E/RS/RW and the select lines of an external datapath. That datapath holds a 4-entry init command ROM, a 4:1 bus mux, two display data registers and a DB bus output enable.
- Runs power-up delay, then the 4-command init sequence, then continuously refreshes two display positions.

Parameters:
- POWERUP_MS, 20, clk_1ms cycles of idle after reset before the first transfer (min 1).
- CMD_WAIT_MS, 2, cycles of post-strobe wait after every transfer (min 1; 2 covers clear-display).
- REFRESH_MS, 50, idle cycles after a complete refresh pass before the next pass (min 1).

Ports:
- clk_1ms  in  1  system clock, 1 kHz; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_sel  out  1  display data register select: 0 = line-1 character register, 1 = line-2 character register; also selects line-1 (0x80) vs line-2 (0xC0) address command.
- DB_sel  out  1  DB[7:0] output enable for the datapath: 1 = drive bus, 0 = release.
- init_sel  out  2  init ROM index: 0 = 0x38 function set, 1 = 0x0C display on, 2 = 0x01 clear, 3 = 0x06 entry mode.
- mux_sel  out  2  bus mux source: 0 = init ROM, 1 = DDRAM address command, 2 = character data, 3 = reserved, never driven.
- E_out  out  1  LCD enable strobe.
- RW_out  out  1  LCD read/write; constant 0, write only, no busy polling.
- RS_out  out  1  LCD register select: 0 = command, 1 = data.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state=POWERUP; delay counter=0; init index=0.
- Outputs are registered and change only on rising clk_1ms.
- POWERUP: hold all outputs 0 for POWERUP_MS cycles, then go to the init sequence.
- Transfer sub-sequence (identical for every byte, 3 + CMD_WAIT_MS cycles):
  - SETUP, 1 cycle: RS_out, mux_sel, init_sel and data_sel set to the transfer's values; DB_sel=1; E_out=0.
  - PULSE, 1 cycle: E_out=1; everything else unchanged.
  - HOLD, 1 cycle: E_out=0; DB_sel=1; selects unchanged (hold time).
  - WAIT, CMD_WAIT_MS cycles: DB_sel=0; E_out=0; selects keep their last value.
- Init: four command transfers, mux_sel=0, RS=0, with init_sel = 0, 1, 2, 3 in order. The index increments in the WAIT→SETUP boundary; after index 3 completes, go to REFRESH.
- REFRESH pass: four transfers in order:
  1. mux_sel=1, data_sel=0, RS=0 (address 0x80)
  2. mux_sel=2, data_sel=0, RS=1 (line-1 char)
  3. mux_sel=1, data_sel=1, RS=0 (address 0xC0)
  4. mux_sel=2, data_sel=1, RS=1 (line-2 char)
- During refresh, init_sel holds 3.
- After a pass: IDLE for REFRESH_MS cycles with all strobes 0 and DB_sel=0, then repeat the pass forever. Init is never re-run except after reset.
- E_out is high for exactly one cycle per transfer. It is never high in the same cycle that RS_out, mux_sel, data_sel or init_sel change.
- Counters are sized for the largest parameter and reset to 0 on each state entry; no wrap-around is possible.
- Reset asserted mid-transfer, including while E_out=1: outputs clear immediately and the sequence restarts from POWERUP after release.
- Reset release is treated as synchronous to the next rising edge. The first cycle counted toward POWERUP is the first edge with reset=1.

Test Plan:
- Hold reset=0 for 3 cycles with the clock running → all seven outputs 0 throughout. Release, and with POWERUP_MS=2 → outputs stay 0 for 2 cycles; SETUP then shows DB_sel=1, mux_sel=0, init_sel=0, RS=0, E=0.
- POWERUP_MS=2, CMD_WAIT_MS=1 → E_out pulses at cycles 3, 7, 11, 15 after release, with init_sel=0, 1, 2, 3 respectively; RS=0 and RW=0 at every pulse.
- Continue → first refresh pulses show (mux_sel, data_sel, RS) = (1,0,0), (2,0,1), (1,1,0), (2,1,1). Then REFRESH_MS idle cycles with E=0 and DB_sel=0, then the same pattern repeats.
- Assert reset while E_out=1 → E_out and all other outputs go to 0 within the same time step, without waiting for a clock edge. After release the init_sel=0 transfer reoccurs after POWERUP_MS.
- Every cycle checker → RW_out==0; mux_sel!=3; E_out never high on two consecutive cycles; selects stable from SETUP through HOLD.
- Default parameters → first E_out pulse exactly 21 cycles after reset release; init complete after 4×5 further cycles.
